// File: rtl/simd_issuer.sv
// simd_issuer: issues one vector command to a SIMD processor using the word
// sequence LD addr0, LD addr1, INFO. It then waits for the processor's finish,
// reports completion to the scoreboard, and releases the processor once the
// scoreboard has flushed the command.
module simd_issuer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_W-1:0]    i_cmd_addr0,
  input  logic [ADDR_W-1:0]    i_cmd_addr1,
  input  logic [1:0]           i_cmd_op,
  input  logic                 i_cmd_overwrite,
  input  logic [COUNT_W-1:0]   i_cmd_count,
  input  logic [ID_W-1:0]      i_cmd_id,
  output logic                 o_en,
  output logic                 o_valid,
  output logic [1:0]           o_instr_opcode,
  output logic [PAYLOAD_W-1:0] o_instr_payload,
  input  logic                 i_ack,
  input  logic                 i_finish,
  input  logic                 i_busy,
  output logic                 o_done,
  output logic [ID_W-1:0]      o_done_id,
  input  logic                 i_flush_ack,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OpNop  = 2'd0;
  localparam logic [1:0] OpLd   = 2'd1;
  localparam logic [1:0] OpInfo = 2'd2;
  localparam logic [1:0] OpRel  = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StEnable, StLd0, StLd1, StInfo, StWaitFin, StReport, StFlush, StRelease
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 en_q, en_d;
  logic                 valid_q, valid_d;
  logic [1:0]           opcode_q, opcode_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;

  logic [ADDR_W-1:0]    addr0_q, addr1_q;
  logic [1:0]           op_q;
  logic                 ow_q;
  logic [COUNT_W-1:0]   count_q;
  logic [ID_W-1:0]      id_q;

  logic                 accept;
  logic                 timed_out;
  logic [1:0]           word_opcode;
  logic [PAYLOAD_W-1:0] word_payload;
  state_e               word_next;

  assign accept    = (state_q == StIdle) && i_cmd_valid && cmd_ready_q;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Latch the command fields on accept; reserved op 3 is issued as add.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr0_q <= '0;
      addr1_q <= '0;
      op_q    <= '0;
      ow_q    <= 1'b0;
      count_q <= '0;
      id_q    <= '0;
    end else if (accept) begin
      addr0_q <= i_cmd_addr0;
      addr1_q <= i_cmd_addr1;
      op_q    <= (i_cmd_op == 2'd3) ? 2'd0 : i_cmd_op;
      ow_q    <= i_cmd_overwrite;
      count_q <= i_cmd_count;
      id_q    <= i_cmd_id;
    end
  end

  // Select the opcode, payload and successor for the current word state.
  always_comb begin
    word_opcode  = OpLd;
    word_payload = PAYLOAD_W'(addr0_q);
    word_next    = StLd1;
    case (state_q)
      StLd1: begin
        word_payload = PAYLOAD_W'(addr1_q);
        word_next    = StInfo;
      end
      StInfo: begin
        word_opcode                  = OpInfo;
        word_payload                 = '0;
        word_payload[1:0]            = op_q;
        word_payload[2]              = ow_q;
        word_payload[COUNT_W+2:3]    = count_q;
        word_next                    = StWaitFin;
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic for the issue FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    en_d        = 1'b0;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    payload_d   = payload_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    timeout_d   = timeout_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (i_cmd_count == '0) begin
            state_d   = StReport;
            done_d    = 1'b1;
            done_id_d = i_cmd_id;
          end else begin
            state_d = StEnable;
            // Pulse enable straight away if the processor is already idle.
            en_d    = !i_busy;
          end
        end
      end
      StEnable: begin
        if (en_q) begin
          state_d   = StLd0;
          valid_d   = 1'b1;
          opcode_d  = OpLd;
          payload_d = PAYLOAD_W'(addr0_q);
        end else begin
          en_d = !i_busy;
        end
      end
      StLd0, StLd1, StInfo: begin
        if (valid_q && i_ack) begin
          // Dropping valid on the ack edge leaves a one-cycle gap between words.
          state_d   = word_next;
          valid_d   = 1'b0;
          opcode_d  = OpNop;
          payload_d = '0;
        end else if (timed_out) begin
          state_d     = StIdle;
          timeout_d   = 1'b1;
          valid_d     = 1'b0;
          opcode_d    = OpNop;
          payload_d   = '0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (!valid_q) begin
          valid_d   = 1'b1;
          opcode_d  = word_opcode;
          payload_d = word_payload;
        end
      end
      StWaitFin: begin
        if (i_finish) begin
          state_d   = StReport;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      StReport: begin
        state_d = StFlush;
      end
      StFlush: begin
        if (i_flush_ack) begin
          if (count_q == '0) begin
            state_d     = StIdle;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d   = StRelease;
            valid_d   = 1'b1;
            opcode_d  = OpRel;
            payload_d = '0;
          end
        end
      end
      StRelease: begin
        if (!i_finish || timed_out) begin
          state_d     = StIdle;
          timeout_d   = timeout_q | i_finish;
          valid_d     = 1'b0;
          opcode_d    = OpNop;
          payload_d   = '0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        valid_d     = 1'b0;
        opcode_d    = OpNop;
        payload_d   = '0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase

    // Fresh count on every state entry; only word and release states count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StLd0, StLd1, StInfo, StRelease}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      opcode_q    <= OpNop;
      payload_q   <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      en_q        <= en_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      payload_q   <= payload_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_en            = en_q;
  assign o_valid         = valid_q;
  assign o_instr_opcode  = opcode_q;
  assign o_instr_payload = payload_q;
  assign o_done          = done_q;
  assign o_done_id       = done_id_q;
  assign o_timeout       = timeout_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_simd_issuer.sv
// Bench for simd_issuer: a table of commands run through a processor and
// scoreboard responder, plus hand sequences for timeout and mid-word reset.
module tb_simd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr0, cmd_addr1, cmd_count;
  logic [1:0]  cmd_op;
  logic        cmd_ow;
  logic [3:0]  cmd_id;
  logic        en, valid;
  logic [1:0]  opcode;
  logic [31:0] payload;
  logic        ack, finish, pbusy;
  logic        done;
  logic [3:0]  done_id;
  logic        flush_ack, tmo, busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  opc;
    logic [31:0] pl;
  } word_t;

  typedef struct {
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  op;
    logic        ow;
    logic [15:0] cnt;
    logic [3:0]  id;
    int          busy_cyc;
    bit          stale;
    logic [31:0] info;
  } vec_t;

  word_t      word_q[$];
  logic [3:0] id_q[$];
  vec_t       vecs[4];

  simd_issuer #(.TIMEOUT(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_addr0     (cmd_addr0),
    .i_cmd_addr1     (cmd_addr1),
    .i_cmd_op        (cmd_op),
    .i_cmd_overwrite (cmd_ow),
    .i_cmd_count     (cmd_count),
    .i_cmd_id        (cmd_id),
    .o_en            (en),
    .o_valid         (valid),
    .o_instr_opcode  (opcode),
    .o_instr_payload (payload),
    .i_ack           (ack),
    .i_finish        (finish),
    .i_busy          (pbusy),
    .o_done          (done),
    .o_done_id       (done_id),
    .i_flush_ack     (flush_ack),
    .o_timeout       (tmo),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_valid = 1'b1;
    cmd_addr0 = v.a0;
    cmd_addr1 = v.a1;
    cmd_op    = v.op;
    cmd_ow    = v.ow;
    cmd_count = v.cnt;
    cmd_id    = v.id;
  endtask

  // Full transaction with a well-behaved processor and scoreboard.
  task automatic run_cmd(input vec_t v);
    int    k;
    int    n;
    int    bad_valid;
    word_t w;
    word_q.delete();
    id_q.delete();
    check("ready_idle", cmd_ready, 1);
    drive_cmd(v);
    pbusy = (v.busy_cyc > 0);
    if (v.cnt != 0) begin
      word_q.push_back('{opc: 2'd1, pl: {16'h0, v.a0}});
      word_q.push_back('{opc: 2'd1, pl: {16'h0, v.a1}});
      word_q.push_back('{opc: 2'd2, pl: v.info});
    end
    id_q.push_back(v.id);
    tick();
    cmd_valid = 1'b0;
    if (v.cnt == 0) begin
      check("zero_done", done, 1);
      check("zero_done_id", done_id, id_q.pop_front());
      check("zero_no_en_valid", {en, valid}, 0);
      tick();
      check("zero_flush_state", {done, en, valid, busy, cmd_ready}, 5'b00010);
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      check("zero_back_idle", {cmd_ready, busy, valid}, 3'b100);
      return;
    end
    k = 1;
    bad_valid = 0;
    while (en !== 1'b1 && k < 20) begin
      if (valid) bad_valid++;
      pbusy = (k < v.busy_cyc);
      tick();
      k++;
    end
    pbusy = 1'b0;
    check("en_latency", k, v.busy_cyc + 1);
    check("no_valid_before_en", bad_valid, 0);
    tick();
    check("en_single_pulse", en, 0);
    check("ld0_latency", valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
          tick();
          ack = 1'b0;
          n++;
        end
        check("word_gap", n, 1);
      end
      if (word_q.size() == 0) begin
        check("scoreboard_underflow", word_q.size(), 1);
        return;
      end
      w = word_q.pop_front();
      check("word_opcode", opcode, w.opc);
      check("word_payload", payload, w.pl);
      tick();
      check("word_hold", {valid, opcode, payload}, {1'b1, w.opc, w.pl});
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("word_drop_on_ack", valid, 0);
      if (v.stale && i < 2) ack = 1'b1;
    end
    tick();
    ack = 1'b0;
    tick();
    check("waitfin_no_done", {done, valid}, 0);
    finish = 1'b1;
    tick();
    check("done_pulse", done, 1);
    check("done_id", done_id, id_q.pop_front());
    tick();
    check("done_one_cycle", {done, valid}, 0);
    tick();
    check("flush_wait", {valid, busy}, 2'b01);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("rel_word", {valid, opcode, payload}, {1'b1, 2'd3, 32'h0});
    tick();
    check("rel_hold", {valid, opcode}, {1'b1, 2'd3});
    finish = 1'b0;
    tick();
    check("rel_to_idle", {valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vec_t v;
    vecs[0] = '{a0: 16'h0100, a1: 16'h0200, op: 2'd2, ow: 1'b1, cnt: 16'd6, id: 4'd3,
                busy_cyc: 0, stale: 1'b0, info: 32'h0000_0036};
    vecs[1] = '{a0: 16'h1234, a1: 16'hABCD, op: 2'd1, ow: 1'b0, cnt: 16'hFFFF, id: 4'hA,
                busy_cyc: 5, stale: 1'b0, info: 32'h0007_FFF9};
    vecs[2] = '{a0: 16'h5555, a1: 16'hAAAA, op: 2'd0, ow: 1'b0, cnt: 16'd0, id: 4'd7,
                busy_cyc: 0, stale: 1'b0, info: 32'h0};
    vecs[3] = '{a0: 16'hFFFF, a1: 16'h0001, op: 2'd0, ow: 1'b1, cnt: 16'd1, id: 4'hF,
                busy_cyc: 0, stale: 1'b1, info: 32'h0000_000C};

    rst = 1'b1;
    cmd_valid = 0; cmd_addr0 = 0; cmd_addr1 = 0; cmd_op = 0; cmd_ow = 0;
    cmd_count = 0; cmd_id = 0; ack = 0; finish = 0; pbusy = 0; flush_ack = 0;
    tick();
    tick();
    check("reset_outputs", {cmd_ready, en, valid, opcode, payload, done, done_id, tmo, busy},
          {1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0});
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_cmd(vecs[i]);
      tick();
    end

    // Timeout: LD0 never acked.
    v = vecs[0];
    v.cnt = 16'd2;
    drive_cmd(v);
    tick();
    cmd_valid = 1'b0;
    check("tmo_en", en, 1);
    tick();
    check("tmo_ld0_valid", valid, 1);
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (tmo !== 1'b0 || valid !== 1'b1) bad++;
    end
    check("tmo_not_early", bad, 0);
    tick();
    check("tmo_fire", {tmo, valid, cmd_ready, busy, done}, 5'b10100);
    tick();
    run_cmd(vecs[0]);
    check("tmo_sticky", tmo, 1);
    tick();

    // Asynchronous reset while LD1 is being offered.
    drive_cmd(vecs[0]);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("pre_rst_ld1", {valid, payload}, {1'b1, 32'h0000_0200});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {cmd_ready, en, valid, opcode, payload, done, done_id, tmo, busy},
          {1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {cmd_ready, busy, valid}, 3'b100);
    run_cmd(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
